spi_master_modes: RTL

Parameterised SPI master supporting all four SPI modes (CPOL/CPHA), a programmable SCLK divider, multiple chip selects and variable packet length. It replaces the mode-0-only master in the SPI block. It uses val/rdy on the transmit, receive and configuration interfaces. Each word accepted on recv is transferred MSB-first, and the received word is returned on send.

---
 rtl/spi_master_modes.sv | 119 +++++++++++
 1 files changed

// File: rtl/spi_master_modes.sv
// spi_master_modes: SPI master with all four CPOL/CPHA modes, programmable SCLK divider,
// multiple chip selects and variable packet length, val/rdy on recv, send and cfg.
module spi_master_modes #(
   parameter int nbits    = 32,
   parameter int ncs      = 4,
   parameter int divw     = 8,
   parameter int logBitsN = $clog2(nbits) + 1,
   parameter int logCSN   = ncs > 1 ? $clog2(ncs) : 1
) (
   input  logic                clk,
   input  logic                reset,
   output logic [ncs-1:0]      spi_cs,
   output logic                spi_sclk,
   output logic                spi_mosi,
   input  logic                spi_miso,
   input  logic                recv_val,
   output logic                recv_rdy,
   input  logic [nbits-1:0]    recv_msg,
   output logic                send_val,
   input  logic                send_rdy,
   output logic [nbits-1:0]    send_msg,
   input  logic                cfg_val,
   output logic                cfg_rdy,
   input  logic [1:0]          cfg_mode,
   input  logic [divw-1:0]     cfg_div,
   input  logic [logCSN-1:0]   cfg_cs_addr,
   input  logic [logBitsN-1:0] cfg_packet_size
);
   typedef enum logic [2:0] {IDLE, LEAD, LEADING_HALF, TRAILING_HALF, TRAIL, DONE} state_t;
   state_t state;
   logic [1:0] mode, mode_n;
   logic [divw-1:0] div, cnt;
   logic [logCSN-1:0] cs_addr, cs_n;
   logic [logBitsN-1:0] size, size_n, bitc, n, n_n;
   logic [nbits-1:0] tx, rx;
   logic [ncs-1:0] cs_sel;
   logic half;
   function automatic logic [logBitsN-1:0] eff(input logic [logBitsN-1:0] s);
      return (s == '0 || 32'(s) > nbits) ? logBitsN'(nbits) : s;
   endfunction
   // A config write accepted together with a transfer already governs that transfer.
   always_comb begin
      mode_n = cfg_val ? cfg_mode : mode;
      size_n = cfg_val ? cfg_packet_size : size;
      cs_n = cfg_val ? cfg_cs_addr : cs_addr;
      n = eff(size);
      n_n = eff(size_n);
      half = cnt == div;
      for (int i = 0; i < ncs; i++) cs_sel[i] = cs_n != logCSN'(i);
   end
   assign recv_rdy = state == IDLE;
   assign cfg_rdy = state == IDLE;
   assign spi_mosi = tx[nbits-1];
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         spi_cs <= '1;
         spi_sclk <= 1'b0;
         send_val <= 1'b0;
         send_msg <= '0;
         mode <= '0;
         div <= '0;
         cs_addr <= '0;
         size <= logBitsN'(nbits);
         cnt <= '0;
         bitc <= '0;
         tx <= '0;
         rx <= '0;
      end else begin
         cnt <= half ? '0 : cnt + 1'b1;
         case (state)
            IDLE: begin
               if (cfg_val) {mode, div, cs_addr, size} <= {cfg_mode, cfg_div, cfg_cs_addr, cfg_packet_size};
               spi_sclk <= mode_n[1];
               if (recv_val) begin
                  tx <= recv_msg << (nbits - int'(n_n));
                  rx <= '0;
                  bitc <= '0;
                  cnt <= '0;
                  spi_cs <= cs_sel;
                  state <= LEAD;
               end
            end
            LEAD: if (half) begin
               spi_sclk <= ~mode[1];
               if (!mode[0]) rx <= {rx[nbits-2:0], spi_miso};
               state <= LEADING_HALF;
            end
            LEADING_HALF: if (half) begin
               spi_sclk <= mode[1];
               if (mode[0]) rx <= {rx[nbits-2:0], spi_miso};
               else tx <= tx << 1;
               state <= TRAILING_HALF;
            end
            TRAILING_HALF: if (half) begin
               bitc <= bitc + 1'b1;
               if (logBitsN'(bitc + 1'b1) == n) state <= TRAIL;
               else begin
                  spi_sclk <= ~mode[1];
                  if (mode[0]) tx <= tx << 1;
                  else rx <= {rx[nbits-2:0], spi_miso};
                  state <= LEADING_HALF;
               end
            end
            TRAIL: if (half) begin
               spi_cs <= '1;
               send_val <= 1'b1;
               send_msg <= rx;
               state <= DONE;
            end
            DONE: if (send_rdy) begin
               send_val <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
